spiflash_read_ctrl: RTL and testbench
=====================================

Name: spiflash_read_ctrl

Overview:
Master-side sequencer for the single-bit SPI flash on the AS2650 memory bus. It powers up the flash with command AB, then serves CPU byte reads using READ (03) + 24-bit address. While the next request is sequential, it keeps CSB low and clocks only 8 more bits. It sits between the CPU fetch/load port and the flash pins (CSB, CLK, IO0 = MOSI, IO1 = MISO); IO2/IO3 are unused.

Parameters:
CLK_DIV, 2, system clocks per SPI half-period (≥1); SPI clock = clk / (2*CLK_DIV).
CSH_CYCLES, 4, minimum system clocks CSB stays high between frames (≥1).
HOLD_MAX, 16, system clocks CSB may idle low awaiting a sequential request before deselect.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
req  in  1  read request; held with addr until rvalid.
addr  in  24  byte address.
rdata  out  8  read data; holds until next rvalid.
rvalid  out  1  one-cycle pulse, rdata valid.
busy  out  1  high from req accept until rvalid, and during power-up.
init_done  out  1  high once the AB frame and its CSB gap complete.
spi_csb  out  1  chip select, active low.
spi_clk  out  1  SPI clock, mode 0 (idles low).
spi_mosi  out  1  to flash IO0.
spi_miso  in  1  from flash IO1.

Behaviour:
- Reset (async assert; synchronous release): spi_csb=1, spi_clk=0, spi_mosi=0, rdata=0, rvalid=0, busy=1, init_done=0. State goes to PWRUP.
- Bit engine: MOSI changes only while spi_clk=0. spi_clk rises CLK_DIV cycles after the MOSI update. spi_miso is registered on the system clock edge that drives spi_clk high. spi_clk falls CLK_DIV cycles later; the next MOSI bit updates on that same edge. Bits are sent MSB first. After the last bit of a frame segment, spi_clk stays 0.
- States:
  - PWRUP: CSB low for ≥1 cycle before the first rising edge. Shift 8'hAB, then go to GAP.
  - GAP: CSB high for CSH_CYCLES. Then IDLE, with init_done=1 and busy=0 if no request is pending.
  - IDLE: if req, latch addr into cur_addr, set busy, go to CMD.
  - CMD: CSB low, shift 32 bits {8'h03, addr[23:0]}, then DATA.
  - DATA: shift 8 bits; MOSI=0; capture spi_miso MSB first. On the 8th sampled bit's falling edge: rdata<=byte, rvalid=1 for one cycle, busy=0, cur_addr<=cur_addr+1 (24-bit wrap, 0xFFFFFF→0x000000). Go to HOLD.
  - HOLD: CSB low, spi_clk 0, hold counter starts at 0.
    - req with addr==cur_addr: DATA directly, no command. The request is accepted on the first cycle req is seen.
    - req with addr≠cur_addr: DESEL, then CMD.
    - Counter reaches HOLD_MAX without req: DESEL, then IDLE.
  - DESEL: CSB high for CSH_CYCLES, then the target state.
- Requests arriving before init_done wait; they are latched in IDLE after GAP.
- req deasserted mid-transaction (protocol violation): the transaction completes and rvalid still pulses.
- req in the rvalid cycle is treated as a new request in HOLD on the next cycle; it is not dropped.
- Latency at CLK_DIV=D, from the req cycle to the rvalid cycle:
  - from IDLE: 1 + 80·D + 1 cycles.
  - sequential from HOLD: 1 + 16·D cycles.
  - non-sequential from HOLD: adds CSH_CYCLES.
- Reset mid-frame: CSB rises immediately (async); the flash aborts. After release the controller re-runs PWRUP.
- No writes, no dual/quad modes; IO2/IO3 left to pull-ups at the top level.

Test Plan:
- Reset release, CLK_DIV=1, CSH_CYCLES=4 → CSB low frame of 8 clocks carrying 0xAB, CSB high ≥4 cycles, then init_done=1, busy=0; spi_clk never toggles with CSB high.
- Flash mem[0x000010]=0x5A; req addr=0x000010 → MOSI bytes 03 00 00 10, 40 spi_clk rising edges, rvalid one cycle with rdata=0x5A, rvalid at 82 cycles after req.
- Then req addr=0x000011 (mem=0xC3) within HOLD_MAX → CSB stays low, exactly 8 spi_clk pulses, no command bytes, rdata=0xC3 at 17 cycles.
- Then req addr=0x000200 → CSB rises for ≥4 cycles, new 03 00 02 00 frame, correct data returned; also idle 16 cycles in HOLD → CSB rises, next req issues a full command.
- Read 0xFFFFFF (0x11), then sequential 0x000000 (0x22) → second read uses no new command; data 0x11 then 0x22.
- Assert rst_n low during the CMD address byte → spi_csb=1 and spi_clk=0 in the same delta, rvalid never pulses; after release the AB power-up frame is re-sent before any 03.

Source files
------------

// File: rtl/spiflash_read_ctrl.sv
// Single-bit SPI flash read sequencer: AB power-up, then READ (03) + 24-bit address,
// keeping the frame open so sequential byte reads cost only 8 more SPI clocks.
module spiflash_read_ctrl #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CSH_CYCLES = 4,
  parameter int unsigned HOLD_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [23:0] addr,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        init_done,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_MAX = (CSH_CYCLES > HOLD_MAX) ? CSH_CYCLES : HOLD_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = 6;
  localparam logic [7:0]  CMD_PWRUP = 8'hAB;
  localparam logic [7:0]  CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_PWRUP, S_GAP, S_IDLE, S_CMD, S_DATA, S_HOLD, S_DESEL
  } state_t;

  state_t             state_q, tgt_q;
  logic               csb_q, sclk_q, mosi_q, rvalid_q, busy_q, init_done_q, run_q;
  logic [7:0]         rdata_q, rx_q;
  logic [23:0]        cur_addr_q;
  logic [31:0]        sh_q;
  logic [BIT_W-1:0]   bits_q;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tick_c, seg_done_c;

  // tick_c marks a half-period boundary; seg_done_c is the falling edge of the last bit
  assign tick_c     = run_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign seg_done_c = tick_c && sclk_q && (bits_q == BIT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      tgt_q       <= S_IDLE;
      csb_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      run_q       <= 1'b0;
      cur_addr_q  <= 24'h0;
      sh_q        <= 32'h0;
      rx_q        <= 8'h00;
      bits_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rvalid_q <= 1'b0;

      // Bit engine: MOSI moves on the falling edge, MISO is captured on the rising edge
      if (tick_c) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], spi_miso};
        end else begin
          sclk_q <= 1'b0;
          if (bits_q == BIT_W'(1)) begin
            run_q  <= 1'b0;
            mosi_q <= 1'b0;
          end else begin
            bits_q <= bits_q - BIT_W'(1);
            mosi_q <= sh_q[31];
            sh_q   <= {sh_q[30:0], 1'b0};
          end
        end
      end else if (run_q) begin
        div_q <= div_q + DIV_W'(1);
      end

      case (state_q)
        S_PWRUP: begin
          if (seg_done_c) begin
            csb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else if (!run_q) begin
            if (csb_q) begin
              csb_q <= 1'b0;
            end else begin
              run_q  <= 1'b1;
              div_q  <= '0;
              bits_q <= BIT_W'(8);
              mosi_q <= CMD_PWRUP[7];
              sh_q   <= {CMD_PWRUP[6:0], 25'h0};
            end
          end
        end

        S_GAP: begin
          if (cnt_q == CNT_W'(CSH_CYCLES - 1)) begin
            init_done_q <= 1'b1;
            busy_q      <= req;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_IDLE: begin
          busy_q <= 1'b0;
          if (req) begin
            cur_addr_q <= addr;
            busy_q     <= 1'b1;
            csb_q      <= 1'b0;
            state_q    <= S_CMD;
          end
        end

        S_CMD: begin
          if (seg_done_c) begin
            run_q   <= 1'b1;
            div_q   <= '0;
            bits_q  <= BIT_W'(8);
            mosi_q  <= 1'b0;
            sh_q    <= 32'h0;
            state_q <= S_DATA;
          end else if (!run_q) begin
            if (csb_q) begin
              csb_q <= 1'b0;
            end else begin
              run_q  <= 1'b1;
              div_q  <= '0;
              bits_q <= BIT_W'(32);
              mosi_q <= CMD_READ[7];
              sh_q   <= {CMD_READ[6:0], cur_addr_q, 1'b0};
            end
          end
        end

        S_DATA: begin
          if (seg_done_c) begin
            rdata_q    <= rx_q;
            rvalid_q   <= 1'b1;
            busy_q     <= 1'b0;
            cur_addr_q <= cur_addr_q + 24'd1;
            cnt_q      <= '0;
            state_q    <= S_HOLD;
          end
        end

        // req in the rvalid cycle still belongs to the finished transfer
        S_HOLD: begin
          if (req && !rvalid_q) begin
            busy_q <= 1'b1;
            if (addr == cur_addr_q) begin
              run_q   <= 1'b1;
              div_q   <= '0;
              bits_q  <= BIT_W'(8);
              mosi_q  <= 1'b0;
              sh_q    <= 32'h0;
              state_q <= S_DATA;
            end else begin
              cur_addr_q <= addr;
              csb_q      <= 1'b1;
              cnt_q      <= '0;
              tgt_q      <= S_CMD;
              state_q    <= S_DESEL;
            end
          end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
            csb_q   <= 1'b1;
            cnt_q   <= '0;
            tgt_q   <= S_IDLE;
            state_q <= S_DESEL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DESEL: begin
          if (cnt_q == CNT_W'(CSH_CYCLES - 1)) begin
            if (tgt_q == S_CMD) begin
              csb_q <= 1'b0;
            end
            state_q <= tgt_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= S_PWRUP;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign spi_csb   = csb_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spiflash_read_ctrl.sv
// Bench for spiflash_read_ctrl: behavioural SPI flash plus latency/data/framing reference model.
module tb_spiflash_read_ctrl;

  localparam int unsigned D        = 1;
  localparam int unsigned CSH      = 4;
  localparam int unsigned HMAX     = 16;
  localparam int unsigned LAT_IDLE = 2 + 80 * D;
  localparam int unsigned LAT_SEQ  = 1 + 16 * D;
  localparam int unsigned LAT_NSEQ = LAT_IDLE + CSH;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [23:0] addr;
  logic [7:0]  rdata;
  logic        rvalid, busy, init_done;
  logic        spi_csb, spi_clk, spi_mosi;
  logic        miso_r;

  spiflash_read_ctrl #(.CLK_DIV(D), .CSH_CYCLES(CSH), .HOLD_MAX(HMAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .init_done(init_done), .spi_csb(spi_csb),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(miso_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000010: mem_byte = 8'h5A;
      24'h000011: mem_byte = 8'hC3;
      24'hFFFFFF: mem_byte = 8'h11;
      24'h000000: mem_byte = 8'h22;
      default:    mem_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h6D;
    endcase
  endfunction

  // Behavioural flash: decode command bytes, stream memory from the decoded address
  int          f_bits = 0;
  int          fk;
  logic [31:0] f_sr = 32'h0;
  logic        f_read = 1'b0;
  logic [23:0] f_addr = 24'h0;
  logic [7:0]  fb;
  logic [7:0]  cmd_log[$];
  logic [23:0] cmd_addr_log[$];
  int          rise_cnt = 0;
  int          bad_clk  = 0;

  initial miso_r = 1'b0;

  always @(negedge spi_csb) begin
    f_bits = 0;
    f_read = 1'b0;
  end

  always @(posedge spi_clk) begin
    rise_cnt++;
    if (spi_csb) begin
      bad_clk++;
    end else begin
      f_sr = {f_sr[30:0], spi_mosi};
      f_bits++;
      if (f_bits == 8) begin
        cmd_log.push_back(f_sr[7:0]);
        f_read = (f_sr[7:0] == 8'h03);
      end
      if (f_bits == 32 && f_read) begin
        f_addr = f_sr[23:0];
        cmd_addr_log.push_back(f_addr);
      end
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_csb && f_read && f_bits >= 32) begin
      fk = f_bits - 32;
      fb = mem_byte(f_addr + 24'(fk / 8));
      miso_r = fb[3'(7 - (fk % 8))];
    end
  end

  // CSB-high run length and rvalid pulse count, sampled mid-cycle
  int hi_cnt     = 0;
  int min_gap    = 1000;
  bit seen_low   = 1'b0;
  int rvalid_cnt = 0;

  always @(negedge clk) begin
    if (spi_csb) begin
      hi_cnt++;
    end else begin
      if (seen_low && hi_cnt > 0 && hi_cnt < min_gap) min_gap = hi_cnt;
      seen_low = 1'b1;
      hi_cnt   = 0;
    end
    if (rvalid) rvalid_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [7:0] last_data = 8'h00;

  task automatic do_read(input string tag, input logic [23:0] a, input int exp_lat, input bit exp_cmd);
    int lat;
    int r0;
    int c0;
    tick();
    check({tag, "_rvalid_pulse"}, 32'(rvalid), 32'h0);
    check({tag, "_rdata_hold"}, 32'(rdata), 32'(last_data));
    req  = 1'b1;
    addr = a;
    r0   = rise_cnt;
    c0   = cmd_addr_log.size();
    lat  = 0;
    while (!rvalid && lat < 2000) begin
      tick();
      lat++;
    end
    req = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, 32'(rdata), 32'(mem_byte(a)));
    check({tag, "_sclk_rises"}, 32'(rise_cnt - r0), exp_cmd ? 32'd40 : 32'd8);
    check({tag, "_cmd_count"}, 32'(cmd_addr_log.size() - c0), exp_cmd ? 32'd1 : 32'd0);
    if (exp_cmd && cmd_addr_log.size() > c0)
      check({tag, "_cmd_addr"}, 32'(cmd_addr_log[$]), 32'(a));
    last_data = mem_byte(a);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  logic [23:0] model_next;
  logic [23:0] ra;
  int          mode;
  int          lat;
  int          n0;
  int          rv0;

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = 24'h0;
    idle(3);
    check("rst_csb", 32'(spi_csb), 32'h1);
    check("rst_sclk", 32'(spi_clk), 32'h0);
    check("rst_mosi", 32'(spi_mosi), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_init_done", 32'(init_done), 32'h0);

    // Power-up frame and CSB gap
    rst_n = 1'b1;
    lat = 0;
    while (!init_done && lat < 500) begin
      tick();
      lat++;
    end
    check("pwrup_init_done", 32'(init_done), 32'h1);
    check("pwrup_busy", 32'(busy), 32'h0);
    check("pwrup_gap", 32'(hi_cnt >= CSH), 32'h1);
    check("pwrup_rises", 32'(rise_cnt), 32'd8);
    check("pwrup_frames", 32'(cmd_log.size()), 32'd1);
    if (cmd_log.size() > 0) check("pwrup_cmd", 32'(cmd_log[0]), 32'hAB);

    // Directed reads
    do_read("first", 24'h000010, LAT_IDLE, 1'b1);
    do_read("seq", 24'h000011, LAT_SEQ, 1'b0);
    do_read("nseq", 24'h000200, LAT_NSEQ, 1'b1);
    idle(HMAX + CSH + 4);
    check("hold_timeout_csb", 32'(spi_csb), 32'h1);
    do_read("after_timeout", 24'h000201, LAT_IDLE, 1'b1);
    do_read("top", 24'hFFFFFF, LAT_NSEQ, 1'b1);
    do_read("wrap", 24'h000000, LAT_SEQ, 1'b0);

    // req dropped mid-transfer still completes
    idle(HMAX + CSH + 4);
    tick();
    req  = 1'b1;
    addr = 24'h000345;
    idle(3);
    req = 1'b0;
    lat = 3;
    while (!rvalid && lat < 2000) begin
      tick();
      lat++;
    end
    check("drop_req_latency", 32'(lat), 32'(LAT_IDLE));
    check("drop_req_rdata", 32'(rdata), 32'(mem_byte(24'h000345)));
    last_data  = mem_byte(24'h000345);
    model_next = 24'h000346;

    // Randomized reads against the latency/command model
    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        idle(int'($urandom_range(0, HMAX - 3)));
        ra = model_next;
        do_read("rnd_seq", ra, LAT_SEQ, 1'b0);
      end else if (mode == 1) begin
        idle(int'($urandom_range(0, HMAX - 3)));
        ra = 24'($urandom);
        if (ra == model_next) ra = ra ^ 24'h000001;
        do_read("rnd_nseq", ra, LAT_NSEQ, 1'b1);
      end else begin
        idle(int'($urandom_range(HMAX + CSH + 4, HMAX + CSH + 16)));
        check("rnd_idle_csb", 32'(spi_csb), 32'h1);
        ra = 24'($urandom);
        do_read("rnd_idle", ra, LAT_IDLE, 1'b1);
      end
      model_next = ra + 24'd1;
    end

    // Reset during the address bytes of a command
    idle(HMAX + CSH + 4);
    tick();
    req  = 1'b1;
    addr = 24'h0ABCDE;
    rv0  = rvalid_cnt;
    idle(30);
    n0    = cmd_log.size();
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check("abort_csb", 32'(spi_csb), 32'h1);
    check("abort_sclk", 32'(spi_clk), 32'h0);
    idle(4);
    check("abort_rvalid_none", 32'(rvalid_cnt - rv0), 32'h0);
    rst_n = 1'b1;
    req   = 1'b1;
    addr  = 24'h000010;
    lat   = 0;
    while (!rvalid && lat < 2000) begin
      tick();
      lat++;
    end
    req = 1'b0;
    check("recover_rvalid", 32'(rvalid), 32'h1);
    check("recover_rdata", 32'(rdata), 32'h5A);
    check("recover_init_done", 32'(init_done), 32'h1);
    check("recover_rvalid_count", 32'(rvalid_cnt - rv0), 32'h1);
    check("recover_frames", 32'(cmd_log.size() - n0), 32'd2);
    if (cmd_log.size() >= n0 + 2) begin
      check("recover_first_ab", 32'(cmd_log[n0]), 32'hAB);
      check("recover_then_03", 32'(cmd_log[n0 + 1]), 32'h03);
    end
    idle(2);

    check("sclk_while_deselected", 32'(bad_clk), 32'h0);
    check("min_csb_gap", 32'(min_gap >= CSH), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
